// File: rtl/fp_pkg.sv
// fp_pkg: flag bit positions, rounding-mode encodings and canonical NaN shared by the adder pipe
package fp_pkg;
  localparam int FLAG_INV = 4;
  localparam int FLAG_OVF = 3;
  localparam int FLAG_UNF = 2;
  localparam int FLAG_NX = 1;
  localparam int FLAG_ZERO = 0;
  typedef enum logic {RM_RNE = 1'b0, RM_RTZ = 1'b1} round_mode_e;
  function automatic logic [63:0] canon_nan(input int exp_w, input int mant_w);
    return (((64'd1 << exp_w) - 64'd1) << mant_w) | (64'd1 << (mant_w - 1));
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter, returns WIDTH for an all-zero input
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) cnt = din[i] ? CW'(WIDTH - 1 - i) : cnt;
  end
endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: four-stage floating-point add/subtract (align, add, normalize, round) with valid/ready flow control
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MANT_W = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  output logic ready_in,
  input  logic [EXP_W+MANT_W:0] op_a,
  input  logic [EXP_W+MANT_W:0] op_b,
  input  logic sub,
  input  logic round_mode,
  output logic valid_out,
  input  logic ready_out,
  output logic [EXP_W+MANT_W:0] result,
  output logic [4:0] flags
);
  localparam int W = 1 + EXP_W + MANT_W;
  localparam int M = MANT_W + 4;
  localparam int CW = $clog2(M + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EMAX_M1 = EMAX - 1'b1;
  localparam logic [W-1:0] QNAN = W'(canon_nan(EXP_W, MANT_W));
  logic adv, v1, v2, v3;
  logic sa, sb, swap, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, inv_ii;
  logic [EXP_W-1:0] ea, eb, el, es, eln, esn, diff;
  logic [MANT_W-1:0] fa, fb, fl, fs;
  logic [M-1:0] ml, msr, msa;
  logic [2*M-1:0] wide;
  logic sg1, sub1, zs1, rm1, byp1, inv1;
  logic [EXP_W-1:0] e1;
  logic [M-1:0] ml1, ms1;
  logic [W-1:0] br1;
  logic sg2, zs2, rm2, byp2, inv2;
  logic [EXP_W-1:0] e2;
  logic [M:0] m2;
  logic [W-1:0] br2;
  logic sg3, zs3, rm3, byp3, inv3;
  logic [EXP_W-1:0] e3, n3e;
  logic [M-1:0] m3, n3m;
  logic [W-1:0] br3;
  logic [CW-1:0] lz;
  int sh;
  logic g, r, s, nx, inc, cy, hid, ovf, zr;
  logic [MANT_W+1:0] mr;
  logic [EXP_W:0] ef;
  logic [MANT_W-1:0] fr;
  logic [EXP_W-1:0] pe;
  logic [W-1:0] r4;
  logic [4:0] f4;
  assign adv = !(valid_out && !ready_out);
  assign ready_in = adv;
  assign {sa, ea, fa} = op_a;
  assign sb = op_b[W-1] ^ sub;
  assign {eb, fb} = op_b[W-2:0];
  assign nan_a = &ea && |fa;
  assign nan_b = &eb && |fb;
  assign snan_a = nan_a && !fa[MANT_W-1];
  assign snan_b = nan_b && !fb[MANT_W-1];
  assign inf_a = &ea && !(|fa);
  assign inf_b = &eb && !(|fb);
  assign inv_ii = inf_a && inf_b && (sa ^ sb);
  assign swap = op_b[W-2:0] > op_a[W-2:0];
  assign {el, fl, es, fs} = swap ? {eb, fb, ea, fa} : {ea, fa, eb, fb};
  assign eln = el == '0 ? EXP_W'(1) : el;
  assign esn = es == '0 ? EXP_W'(1) : es;
  assign diff = eln - esn;
  assign ml = {|el, fl, 3'b000};
  assign msr = {|es, fs, 3'b000};
  assign wide = {msr, M'(0)} >> diff;
  assign msa = int'(diff) >= M - 1 ? {{(M-1){1'b0}}, |msr} : {wide[2*M-1:M+1], wide[M] | (|wide[M-1:0])};
  fp_lzc #(.WIDTH(M)) u_lzc (.din(m2[M-1:0]), .cnt(lz));
  assign sh = int'(lz) < int'(e2) - 1 ? int'(lz) : int'(e2) - 1;
  assign n3m = m2[M] ? {m2[M:2], |m2[1:0]} : m2[M-1:0] << sh;
  assign n3e = m2[M] ? e2 + 1'b1 : e2 - EXP_W'(sh);
  assign {g, r, s} = m3[2:0];
  assign nx = g | r | s;
  assign inc = rm3 == RM_RNE && g && (r | s | m3[3]);
  assign mr = {1'b0, m3[M-1:3]} + (MANT_W+2)'(inc);
  assign cy = mr[MANT_W+1];
  assign ef = {1'b0, e3} + (EXP_W+1)'(cy);
  assign hid = cy | mr[MANT_W];
  assign fr = cy ? mr[MANT_W:1] : mr[MANT_W-1:0];
  assign ovf = ef >= {1'b0, EMAX};
  assign pe = hid ? ef[EXP_W-1:0] : '0;
  assign zr = !hid && fr == '0;
  assign r4 = byp3 ? br3 : ovf ? (rm3 == RM_RTZ ? {sg3, EMAX_M1, {MANT_W{1'b1}}} : {sg3, EMAX, {MANT_W{1'b0}}}) : {zr ? zs3 : sg3, pe, fr};
  always_comb begin
    f4 = '0;
    f4[FLAG_INV] = byp3 && inv3;
    f4[FLAG_OVF] = !byp3 && ovf;
    f4[FLAG_UNF] = !byp3 && !ovf && !hid && nx;
    f4[FLAG_NX] = !byp3 && (nx || ovf);
    f4[FLAG_ZERO] = !byp3 && !ovf && zr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      valid_out <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (adv) begin
      v1 <= valid_in;
      v2 <= v1;
      v3 <= v2;
      valid_out <= v3;
      result <= r4;
      flags <= f4;
    end
  always_ff @(posedge clk)
    if (adv) begin
      sg1 <= swap ? sb : sa;
      sub1 <= sa ^ sb;
      zs1 <= sa & sb;
      rm1 <= round_mode;
      byp1 <= nan_a | nan_b | inf_a | inf_b;
      inv1 <= snan_a | snan_b | inv_ii;
      br1 <= (nan_a || nan_b || inv_ii) ? QNAN : inf_a ? op_a : {sb, op_b[W-2:0]};
      e1 <= eln;
      ml1 <= ml;
      ms1 <= msa;
      sg2 <= sg1;
      zs2 <= zs1;
      rm2 <= rm1;
      byp2 <= byp1;
      inv2 <= inv1;
      br2 <= br1;
      e2 <= e1;
      m2 <= sub1 ? {1'b0, ml1} - {1'b0, ms1} : {1'b0, ml1} + {1'b0, ms1};
      sg3 <= sg2;
      zs3 <= zs2;
      rm3 <= rm2;
      byp3 <= byp2;
      inv3 <= inv2;
      br3 <= br2;
      e3 <= n3e;
      m3 <= n3m;
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed scoreboard bench for the floating-point adder pipe
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid_in, ready_in, sub, round_mode, valid_out, ready_out;
  logic [31:0] op_a, op_b, result;
  logic [4:0] flags;
  typedef struct {
    logic [31:0] res;
    logic [4:0] flg;
    int cyc;
    bit lat;
    int id;
  } exp_t;
  exp_t scb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit held_v = 1'b0;
  logic [31:0] hres;
  logic [4:0] hflg;
  logic [31:0] fv [1:9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
  fp_add_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .op_a(op_a),
    .op_b(op_b),
    .sub(sub),
    .round_mode(round_mode),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .result(result),
    .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic rm,
                      input logic [31:0] er, input logic [4:0] efl, input bit lat, input int id);
    exp_t n;
    int k;
    op_a = a;
    op_b = b;
    sub = s;
    round_mode = rm;
    valid_in = 1'b1;
    k = 0;
    @(negedge clk);
    while (!ready_in && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready_in) chk($sformatf("accept_timeout%0d", id), 32'(ready_in), 32'd1);
    n.res = er;
    n.flg = efl;
    n.cyc = cyc;
    n.lat = lat;
    n.id = id;
    scb.push_back(n);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask
  task automatic drain;
    for (int i = 0; i < 60 && scb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", scb.size(), 32'd0);
  endtask
  initial begin
    valid_in = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    round_mode = 1'b0;
    ready_out = 1'b1;
    fork
      forever @(posedge clk) cyc++;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (held_v) begin
            chk("hold_valid", 32'(valid_out), 32'd1);
            chk("hold_result", result, hres);
            chk("hold_flags", 32'(flags), 32'(hflg));
          end
          if (valid_out && ready_out) begin
            if (scb.size() == 0) chk("spurious_out", 32'(valid_out), 32'd0);
            else begin
              e = scb.pop_front();
              chk($sformatf("res%0d", e.id), result, e.res);
              chk($sformatf("flags%0d", e.id), 32'(flags), 32'(e.flg));
              if (e.lat) chk($sformatf("latency%0d", e.id), cyc - e.cyc, 32'd4);
            end
          end
          held_v = valid_out && !ready_out;
          if (held_v) begin
            stall_cnt++;
            chk("ready_in_stall", 32'(ready_in), 32'd0);
            hres = result;
            hflg = flags;
          end
        end else held_v = 1'b0;
      end
    join_none
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 5'h00, 1'b1, 0);
    send(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 5'h01, 1'b1, 1);
    send(32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 5'h02, 1'b1, 2);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 5'h0A, 1'b1, 3);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 5'h0A, 1'b1, 4);
    send(32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 5'h10, 1'b1, 5);
    send(32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 5'h00, 1'b1, 6);
    send(32'h40400000, 32'h3F800000, 1'b1, 1'b0, 32'h40000000, 5'h00, 1'b1, 7);
    send(32'h3F800000, 32'h40400000, 1'b1, 1'b0, 32'hC0000000, 5'h00, 1'b1, 8);
    send(32'h3F800000, 32'h3F400000, 1'b1, 1'b0, 32'h3E800000, 5'h00, 1'b1, 9);
    send(32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800002, 5'h02, 1'b1, 10);
    send(32'h3F800001, 32'h33800000, 1'b0, 1'b1, 32'h3F800001, 5'h02, 1'b1, 11);
    send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 5'h01, 1'b1, 12);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 5'h00, 1'b1, 13);
    send(32'h7F800001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 5'h10, 1'b1, 14);
    send(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 5'h00, 1'b1, 15);
    send(32'h00400000, 32'h00400000, 1'b0, 1'b0, 32'h00800000, 5'h00, 1'b1, 16);
    send(32'hFF800000, 32'h3F800000, 1'b0, 1'b0, 32'hFF800000, 5'h00, 1'b1, 17);
    send(32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 32'h00000000, 5'h01, 1'b1, 18);
    send(32'h00000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 5'h01, 1'b1, 19);
    drain();
    @(posedge clk);
    #1;
    fork
      for (int k = 1; k <= 8; k++) send(fv[k], 32'h3F800000, 1'b0, 1'b0, fv[k+1], 5'h00, 1'b0, 100 + k);
      begin
        repeat (6) @(posedge clk);
        #1 ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", stall_cnt, 32'd3);
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 5'h00, 1'b1, 200);
    send(32'h40400000, 32'h3F800000, 1'b0, 1'b0, 32'h40800000, 5'h00, 1'b1, 201);
    send(32'h40800000, 32'h3F800000, 1'b0, 1'b0, 32'h40A00000, 5'h00, 1'b1, 202);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_ready_in", 32'(ready_in), 32'd1);
    scb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send(32'h40000000, 32'h3F800000, 1'b0, 1'b0, 32'h40400000, 5'h00, 1'b1, 300);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MANT_W, default 23, stored fraction width; word width W = 1+EXP_W+MANT_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 valid_in  input  1  operand pair present.
REQ-006 ready_in  output  1  block accepts operands this cycle.
REQ-007 op_a, op_b  input  W each  IEEE-style operands {sign, exp, frac}.
REQ-008 sub  input  1  1 computes op_a-op_b; 0 computes op_a+op_b.
REQ-009 round_mode  input  1  0 round-nearest-even, 1 round-toward-zero.
REQ-010 valid_out  output  1  result present.
REQ-011 ready_out  input  1  downstream accepts result.
REQ-012 result  output  W  rounded sum/difference.
REQ-013 flags  output  5  {invalid, overflow, underflow, inexact, zero}, bit 4 down to bit 0.

Function
REQ-014 The block SHALL be a 4-stage pipeline: S1 unpack/swap/align, S2 magnitude add/sub, S3 normalize, S4 round/pack; latency exactly 4 cycles with no stalls.
REQ-015 A transfer SHALL occur on valid_in&&ready_in at input and valid_out&&ready_out at output.
REQ-016 ready_in SHALL equal !(valid_out && !ready_out); when stalled, every stage register SHALL hold, including bubbles.
REQ-017 result and flags SHALL stay stable while valid_out=1 and ready_out=0.
REQ-018 Back-to-back accepts SHALL give throughput of one result per cycle.
REQ-019 Effective sign of op_b SHALL be sign_b XOR sub.
REQ-020 S1 SHALL swap so the larger magnitude is operand L; hidden bit 1 for exp≠0, 0 with exponent treated as 1 for exp=0 (subnormal).
REQ-021 S1 SHALL right-shift the smaller mantissa by the exponent difference into MANT_W+4 bits (hidden, fraction, guard, round, sticky), OR-ing all shifted-out bits into sticky; shifts ≥ MANT_W+3 yield sticky only.
REQ-022 S2 SHALL add on equal effective signs, else subtract smaller from larger, keeping carry-out; result sign is sign of L.
REQ-023 S3 SHALL shift right 1 and increment exponent on carry-out (sticky preserved), else left-shift by leading-zero count, limited so exponent does not drop below 1; exponent 1 with hidden bit 0 packs as exp=0.
REQ-024 S4 SHALL round with guard/round/sticky: RNE increments on G&(R|S|lsb); RTZ never increments; mantissa carry from rounding renormalizes and increments exponent.
REQ-025 inexact SHALL be set when any of G, R, S is 1 after normalization.
REQ-026 Exponent reaching all-ones after rounding SHALL set overflow and inexact; result +/-Inf under RNE, +/-max finite under RTZ.
REQ-027 underflow SHALL be set when the packed result is subnormal or zero and inexact.
REQ-028 Exact zero magnitude SHALL give +0 unless both effective operands are -0 (then -0); zero flag set for any zero result.
REQ-029 Any NaN operand, or Inf minus Inf of equal magnitude, SHALL give canonical quiet NaN (sign 0, exp all-ones, fraction MSB 1 only); invalid set only for signalling NaN input or Inf-Inf.
REQ-030 Inf with finite operand SHALL return that Inf with no flags.
REQ-031 Special-case decisions SHALL be made in S1 and carried as a bypass tag through the pipe, keeping uniform latency.

Reset
REQ-032 During rst_n=0: valid_out=0, result=0, flags=0, all stage valid bits 0, ready_in=1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight operations; no result for them appears after release.

Structure
REQ-034 A shared package fp_pkg SHALL hold flag bit indices, round-mode encodings, and the canonical-NaN constant function of EXP_W/MANT_W.
REQ-035 Leading-zero count SHALL be a sub-module fp_lzc, parameterised by width, purely combinational.

Verification
REQ-036 0x3F800000 + 0x3F800000, RNE, ready_out=1 -> 0x40000000, flags 0, valid_out exactly 4 cycles after accept.
REQ-037 0x3F800000 with sub=1, same op_b -> 0x00000000, flags zero only; 0x3F800000 + 0x33800000 RNE -> 0x3F800000, inexact (tie to even).
REQ-038 0x7F7FFFFF + 0x7F7FFFFF -> RNE 0x7F800000, RTZ 0x7F7FFFFF; both overflow|inexact.
REQ-039 0x7F800000 with sub=1, op_b 0x7F800000 -> 0x7FC00000, invalid; 0x7F800000 + 0x3F800000 -> 0x7F800000, flags 0.
REQ-040 Stream 8 ops with ready_out low for 3 cycles mid-stream -> ready_in low during stall, held output stable, all 8 results in order, none lost or duplicated.
REQ-041 Assert rst_n low with 3 ops in flight -> outputs zero immediately, no stale result after release.
